// File: rtl/time_keeper.sv
// HH:MM:SS timekeeper: counts up or down once per T_TICK cycles, with per-field adjust,
// clamped parallel load, configurable hour modulus, and a countdown terminal flag.
module time_keeper #(
  parameter int unsigned T_TICK       = 100_000_000,
  parameter int unsigned T_TICK_WIDTH = $clog2(T_TICK),
  parameter int unsigned HOUR_MAX     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        count_down,
  input  logic        adj_sec,
  input  logic        adj_min,
  input  logic        adj_hour,
  input  logic        load,
  input  logic [7:0]  load_hours,
  input  logic [7:0]  load_minutes,
  input  logic [7:0]  load_seconds,
  output logic [7:0]  hours,
  output logic [7:0]  minutes,
  output logic [7:0]  seconds,
  output logic [23:0] number,
  output logic [23:0] bcd,
  output logic        tick,
  output logic        expired
);

  localparam logic [7:0]              HR_LAST    = 8'(HOUR_MAX - 1);
  localparam logic [7:0]              MS_LAST    = 8'd59;
  localparam logic [T_TICK_WIDTH-1:0] PRESC_LAST = T_TICK_WIDTH'(T_TICK - 1);

  typedef enum logic [1:0] {STOP, RUN, EXPIRED} state_e;

  state_e                  state_q, state_d;
  logic [T_TICK_WIDTH-1:0] presc_q, presc_d;
  logic [7:0]              hours_q, hours_d;
  logic [7:0]              minutes_q, minutes_d;
  logic [7:0]              seconds_q, seconds_d;
  logic                    tick_q, tick_d;
  logic                    expired_q, expired_d;
  logic                    any_adj;
  logic                    time_zero;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    tick_d    = 1'b0;
    expired_d = expired_q;
    any_adj   = adj_sec | adj_min | adj_hour;
    time_zero = (hours_q == 8'd0) && (minutes_q == 8'd0) && (seconds_q == 8'd0);

    if (load) begin
      hours_d   = (load_hours >= 8'(HOUR_MAX)) ? HR_LAST : load_hours;
      minutes_d = (load_minutes > MS_LAST) ? MS_LAST : load_minutes;
      seconds_d = (load_seconds > MS_LAST) ? MS_LAST : load_seconds;
      presc_d   = '0;
      expired_d = 1'b0;
      state_d   = STOP;
    end else begin
      // Adjusts wrap within their own field and never carry.
      if (adj_sec)  seconds_d = (seconds_q == MS_LAST) ? 8'd0 : seconds_q + 8'd1;
      if (adj_min)  minutes_d = (minutes_q == MS_LAST) ? 8'd0 : minutes_q + 8'd1;
      if (adj_hour) hours_d   = (hours_q == HR_LAST) ? 8'd0 : hours_q + 8'd1;

      case (state_q)
        STOP: begin
          presc_d = '0;
          if (run) state_d = RUN;
        end
        RUN: begin
          if (!run) begin
            presc_d = '0;
            state_d = STOP;
          end else if (count_down && time_zero) begin
            presc_d   = '0;
            expired_d = 1'b1;
            state_d   = EXPIRED;
          end else if (any_adj) begin
            presc_d = presc_q;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (!count_down) begin
              if (seconds_q != MS_LAST) begin
                seconds_d = seconds_q + 8'd1;
              end else begin
                seconds_d = 8'd0;
                if (minutes_q != MS_LAST) begin
                  minutes_d = minutes_q + 8'd1;
                end else begin
                  minutes_d = 8'd0;
                  hours_d   = (hours_q == HR_LAST) ? 8'd0 : hours_q + 8'd1;
                end
              end
            end else begin
              // Time is nonzero here, so a full borrow always finds hours > 0.
              if (seconds_q != 8'd0) begin
                seconds_d = seconds_q - 8'd1;
              end else begin
                seconds_d = MS_LAST;
                if (minutes_q != 8'd0) begin
                  minutes_d = minutes_q - 8'd1;
                end else begin
                  minutes_d = MS_LAST;
                  hours_d   = hours_q - 8'd1;
                end
              end
              if ((hours_d == 8'd0) && (minutes_d == 8'd0) && (seconds_d == 8'd0)) begin
                expired_d = 1'b1;
                state_d   = EXPIRED;
              end
            end
          end else begin
            presc_d = presc_q + T_TICK_WIDTH'(1);
          end
        end
        EXPIRED: begin
          presc_d   = '0;
          expired_d = 1'b1;
        end
        default: state_d = STOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STOP;
      presc_q   <= '0;
      hours_q   <= 8'd0;
      minutes_q <= 8'd0;
      seconds_q <= 8'd0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign tick    = tick_q;
  assign expired = expired_q;

  // Display path decodes straight from the time registers.
  assign number = 24'(hours_q) * 24'd10000 + 24'(minutes_q) * 24'd100 + 24'(seconds_q);
  assign bcd    = {4'(hours_q / 8'd10),   4'(hours_q % 8'd10),
                   4'(minutes_q / 8'd10), 4'(minutes_q % 8'd10),
                   4'(seconds_q / 8'd10), 4'(seconds_q % 8'd10)};

endmodule
